// File: rtl/jtcps1_pkg.sv
// Shared types and constants for the CPS1 tilemap line buffer.
// Pixel word is {pal, colour}; the FSM enum covers the renderer start/done handshake.
package jtcps1_pkg;
   localparam int LBUF_AW = 9;
   localparam int LBUF_DW = 9;
   localparam logic [LBUF_DW-1:0] LBUF_BLANK = 9'h1FF;

   typedef struct packed {
      logic [4:0] pal;
      logic [3:0] colour;
   } lbuf_pxl_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } lbuf_st_e;

   // Read address wraps at 512 so renderer fine-scroll writes below 0 line up.
   function automatic logic [LBUF_AW-1:0] lbuf_raddr(input logic [LBUF_AW-1:0] h,
                                                     input logic [LBUF_AW-1:0] off);
      return h + off;
   endfunction
endpackage

// File: rtl/jtcps1_linebuf_if.sv
// Renderer-to-line-buffer bus: write strobe/address/data plus the start/done handshake.
// master = tilemap renderer, slave = line buffer.
interface jtcps1_linebuf_if;
   import jtcps1_pkg::*;

   logic                 start;
   logic                 done;
   logic [LBUF_AW-1:0]   buf_addr;
   lbuf_pxl_t            buf_data;
   logic                 buf_wr;

   modport master(input start, output done, output buf_addr, output buf_data, output buf_wr);
   modport slave (output start, input done, input buf_addr, input buf_data, input buf_wr);
endinterface

// File: rtl/jtcps1_lbuf_ram.sv
// 1024x9 dual-port line RAM, address {bank, addr}: port A renderer writes, port B read + blanking write.
// Latency: port B read data one clk after b_rd; no backpressure, every access completes in one clk.
module jtcps1_lbuf_ram
   import jtcps1_pkg::*;
#(
   parameter logic [LBUF_DW-1:0] BLANK = LBUF_BLANK
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               a_we,
   input  logic [LBUF_AW:0]   a_addr,
   input  lbuf_pxl_t          a_dat,
   input  logic               b_rd,
   input  logic [LBUF_AW:0]   b_raddr,
   input  logic               b_we,
   input  logic [LBUF_AW:0]   b_waddr,
   output lbuf_pxl_t          b_q
);
   lbuf_pxl_t mem [0:(1<<(LBUF_AW+1))-1];

   // Renderer write is last so it wins over a blanking write to the same word.
   always_ff @(posedge clk) begin
      if (b_we) mem[b_waddr] <= BLANK;
      if (a_we) mem[a_addr]  <= a_dat;
   end

   always_ff @(posedge clk) begin
      if (rst)       b_q <= BLANK;
      else if (b_rd) b_q <= mem[b_raddr];
   end
endmodule

// File: rtl/jtcps1_linebuf.sv
// Double-buffered tilemap line store with start/done handshake; JTCPS1_LBUF_CLR_EN blanks each pixel after readout.
// Latency: pxl valid one clk after pxl_cen; start rises one clk after line_start.
// No backpressure: writes always accepted; late pulses when a line ends before the renderer is done.
module jtcps1_linebuf
   import jtcps1_pkg::*;
#(
   parameter logic [LBUF_AW-1:0] HOFFSET = 9'd0,
   parameter logic [LBUF_DW-1:0] BLANK   = LBUF_BLANK
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pxl_cen,
   input  logic [LBUF_AW-1:0]   hdump,
   input  logic                 line_start,
   jtcps1_linebuf_if.slave      rbus,
   output lbuf_pxl_t            pxl,
   output logic                 late
);
   logic               bank;
   logic [LBUF_AW-1:0] raddr;
   logic               clr_we;
   logic [LBUF_AW:0]   clr_addr;
   lbuf_st_e           st, st_nxt;
   logic               pending, pending_nxt;
   logic               late_nxt;
   logic               start_c;

   assign raddr = lbuf_raddr(hdump, HOFFSET);

   // A write in the line_start cycle still lands in the pre-toggle bank.
   always_ff @(posedge clk) begin
      if (rst)             bank <= 1'b0;
      else if (line_start) bank <= ~bank;
   end

`ifdef JTCPS1_LBUF_CLR_EN
   // Bank and address are registered so the clear follows the word just read even across a swap.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_we   <= 1'b0;
         clr_addr <= '0;
      end else begin
         clr_we   <= pxl_cen;
         clr_addr <= {~bank, raddr};
      end
   end
`else
   assign clr_we   = 1'b0;
   assign clr_addr = '0;
`endif

   jtcps1_lbuf_ram #(.BLANK(BLANK)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .a_we    (rbus.buf_wr),
      .a_addr  ({bank, rbus.buf_addr}),
      .a_dat   (rbus.buf_data),
      .b_rd    (pxl_cen),
      .b_raddr ({~bank, raddr}),
      .b_we    (clr_we),
      .b_waddr (clr_addr),
      .b_q     (pxl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= ST_IDLE;
         pending <= 1'b0;
         late    <= 1'b0;
      end else begin
         st      <= st_nxt;
         pending <= pending_nxt;
         late    <= late_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         ST_IDLE: if (line_start) st_nxt = ST_REQ;
         ST_REQ:  if (rbus.done)  st_nxt = ST_ACK;
         ST_ACK:  if (!rbus.done) st_nxt = (pending || line_start) ? ST_REQ : ST_IDLE;
         default: st_nxt = ST_IDLE;
      endcase
   end

   // A line_start while the renderer is mid-line is flagged but not restarted; it finishes into the new bank.
   always_comb begin
      start_c     = (st == ST_REQ);
      late_nxt    = 1'b0;
      pending_nxt = pending;
      case (st)
         ST_REQ: begin
            late_nxt = line_start & ~rbus.done;
            if (line_start && rbus.done) pending_nxt = 1'b1;
         end
         ST_ACK: begin
            if (!rbus.done)      pending_nxt = 1'b0;
            else if (line_start) pending_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   assign rbus.start = start_c;
endmodule
